// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of the dual-port data RAM (one write port,
// one synchronous read port). Read and write channels are arbitrated
// independently with two-way round-robin. Also handles the 1-cycle read
// latency, same-cycle write-to-read bypass and out-of-range rejection.
module dmem_arbiter #(
    parameter int unsigned AW       = 24,
    parameter int unsigned DW       = 24,
    parameter int unsigned MEM_SIZE = 2048
) (
    input  logic          clk,
    input  logic          rst,
    // port 0 (processor)
    input  logic          p0_rreq,
    input  logic [AW-1:0] p0_raddr,
    output logic          p0_rgnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,
    input  logic          p0_wreq,
    input  logic [AW-1:0] p0_waddr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_wgnt,
    // port 1 (debug/DMA loader)
    input  logic          p1_rreq,
    input  logic [AW-1:0] p1_raddr,
    output logic          p1_rgnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,
    input  logic          p1_wreq,
    input  logic [AW-1:0] p1_waddr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_wgnt,
    // dpdmem side
    output logic [AW-1:0] m_raddr,
    input  logic [DW-1:0] m_rdata,
    output logic [AW-1:0] m_waddr,
    output logic [DW-1:0] m_wdata,
    output logic          m_wen,
    output logic          err
);

    // Pointer value is the preferred port on contention (0 = port 0).
    logic          rd_pref_q, wr_pref_q;
    logic          rd_sel, wr_sel;
    logic          rd_any, wr_any;
    logic          r_inrange, w_inrange, bypass;
    // Read pipeline: one in-flight read, tagged with port, range and bypass.
    logic          rv_q, rport_q, rinr_q, rbyp_q;
    logic [DW-1:0] byp_data_q;
    logic [DW-1:0] p0_hold_q, p1_hold_q;
    logic [DW-1:0] rd_cur;
    logic          err_q;

    // Read channel grant: a lone requester wins, otherwise the pointer decides.
    always_comb begin
        rd_sel = 1'b0;
        if (p0_rreq && p1_rreq) begin
            rd_sel = rd_pref_q;
        end else if (p1_rreq) begin
            rd_sel = 1'b1;
        end
        rd_any    = rst && (p0_rreq || p1_rreq);
        p0_rgnt   = rd_any && !rd_sel;
        p1_rgnt   = rd_any && rd_sel;
        m_raddr   = rd_sel ? p1_raddr : p0_raddr;
        r_inrange = (m_raddr < AW'(MEM_SIZE));
    end

    // Write channel grant and dpdmem write drive; out-of-range writes are
    // granted but never reach the RAM.
    always_comb begin
        wr_sel = 1'b0;
        if (p0_wreq && p1_wreq) begin
            wr_sel = wr_pref_q;
        end else if (p1_wreq) begin
            wr_sel = 1'b1;
        end
        wr_any    = rst && (p0_wreq || p1_wreq);
        p0_wgnt   = wr_any && !wr_sel;
        p1_wgnt   = wr_any && wr_sel;
        m_waddr   = wr_sel ? p1_waddr : p0_waddr;
        m_wdata   = wr_sel ? p1_wdata : p0_wdata;
        w_inrange = (m_waddr < AW'(MEM_SIZE));
        m_wen     = wr_any && w_inrange;
        // RAM reads old data on a same-address collision, so forward wdata.
        bypass    = rd_any && r_inrange && m_wen && (m_raddr == m_waddr);
    end

    // Round-robin pointers move only on a grant, away from the granted port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_pref_q <= 1'b0;
            wr_pref_q <= 1'b0;
        end else begin
            if (rd_any) rd_pref_q <= !rd_sel;
            if (wr_any) wr_pref_q <= !wr_sel;
        end
    end

    // Read return path: tag the granted read, hold last data per port, flag errors.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rv_q       <= 1'b0;
            rport_q    <= 1'b0;
            rinr_q     <= 1'b0;
            rbyp_q     <= 1'b0;
            byp_data_q <= '0;
            p0_hold_q  <= '0;
            p1_hold_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            rv_q    <= rd_any;
            rport_q <= rd_sel;
            rinr_q  <= r_inrange;
            rbyp_q  <= bypass;
            if (bypass) byp_data_q <= m_wdata;
            if (p0_rvalid) p0_hold_q <= rd_cur;
            if (p1_rvalid) p1_hold_q <= rd_cur;
            // One pulse even if both channels are out of range together.
            err_q <= (rd_any && !r_inrange) || (wr_any && !w_inrange);
        end
    end

    // Steer returning data to the port that owns the in-flight read.
    always_comb begin
        if (!rinr_q) begin
            rd_cur = '0;
        end else if (rbyp_q) begin
            rd_cur = byp_data_q;
        end else begin
            rd_cur = m_rdata;
        end
        p0_rvalid = rv_q && !rport_q;
        p1_rvalid = rv_q && rport_q;
        p0_rdata  = p0_rvalid ? rd_cur : p0_hold_q;
        p1_rdata  = p1_rvalid ? rd_cur : p1_hold_q;
        err       = err_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural dpdmem behind it.
module tb_dmem_arbiter;

    logic        clk, rst;
    logic        p0_rreq, p0_rgnt, p0_rvalid, p0_wreq, p0_wgnt;
    logic [23:0] p0_raddr, p0_rdata, p0_waddr, p0_wdata;
    logic        p1_rreq, p1_rgnt, p1_rvalid, p1_wreq, p1_wgnt;
    logic [23:0] p1_raddr, p1_rdata, p1_waddr, p1_wdata;
    logic [23:0] m_raddr, m_rdata, m_waddr, m_wdata;
    logic        m_wen, err;
    logic [23:0] mem [0:2047];
    int          n_cmp, n_bad;

    dmem_arbiter #(.AW(24), .DW(24), .MEM_SIZE(2048)) dut (
        .clk(clk), .rst(rst),
        .p0_rreq(p0_rreq), .p0_raddr(p0_raddr), .p0_rgnt(p0_rgnt),
        .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p0_wreq(p0_wreq), .p0_waddr(p0_waddr), .p0_wdata(p0_wdata), .p0_wgnt(p0_wgnt),
        .p1_rreq(p1_rreq), .p1_raddr(p1_raddr), .p1_rgnt(p1_rgnt),
        .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .p1_wreq(p1_wreq), .p1_waddr(p1_waddr), .p1_wdata(p1_wdata), .p1_wgnt(p1_wgnt),
        .m_raddr(m_raddr), .m_rdata(m_rdata), .m_waddr(m_waddr), .m_wdata(m_wdata),
        .m_wen(m_wen), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // dpdmem model: synchronous read returns pre-write contents
    always @(posedge clk) begin
        if (m_wen) mem[m_waddr[10:0]] <= m_wdata;
        m_rdata <= mem[m_raddr[10:0]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        p0_rreq = 0; p0_wreq = 0; p1_rreq = 0; p1_wreq = 0;
    endtask

    task automatic test_reset();
        rst = 0;
        p0_rreq = 1; p0_raddr = 24'd5; p0_wreq = 1; p0_waddr = 24'd100; p0_wdata = 24'hDEAD00;
        p1_rreq = 1; p1_raddr = 24'd6; p1_wreq = 1; p1_waddr = 24'd101; p1_wdata = 24'hBEEF00;
        tick(); tick();
        n_cmp++; if ({p0_rgnt, p1_rgnt, p0_wgnt, p1_wgnt} !== 4'b0000) begin
            n_bad++; $display("FAIL rst_grants got=%b want=0000", {p0_rgnt, p1_rgnt, p0_wgnt, p1_wgnt}); end
        n_cmp++; if (m_wen !== 1'b0) begin n_bad++; $display("FAIL rst_m_wen got=%b want=0", m_wen); end
        n_cmp++; if ({p0_rvalid, p1_rvalid, err} !== 3'b000) begin
            n_bad++; $display("FAIL rst_rvalid_err got=%b want=000", {p0_rvalid, p1_rvalid, err}); end
        n_cmp++; if (p0_rdata !== 24'h0 || p1_rdata !== 24'h0) begin
            n_bad++; $display("FAIL rst_rdata got=%h/%h want=0/0", p0_rdata, p1_rdata); end
        rst = 1;
        #1;
        n_cmp++; if ({p0_rgnt, p1_rgnt, p0_wgnt, p1_wgnt} !== 4'b1010) begin
            n_bad++; $display("FAIL rst_release_grants got=%b want=1010", {p0_rgnt, p1_rgnt, p0_wgnt, p1_wgnt}); end
        idle();
        tick();
    endtask

    task automatic test_single_write();
        p0_wreq = 1; p0_waddr = 24'd5; p0_wdata = 24'h00ABCD;
        #1;
        n_cmp++; if (p0_wgnt !== 1'b1 || m_wen !== 1'b1) begin
            n_bad++; $display("FAIL wr_p0_gnt got=%b%b want=11", p0_wgnt, m_wen); end
        n_cmp++; if (m_waddr !== 24'd5 || m_wdata !== 24'h00ABCD) begin
            n_bad++; $display("FAIL wr_p0_bus got=%h/%h want=000005/00abcd", m_waddr, m_wdata); end
        tick();
        p0_wreq = 0; p1_wreq = 1; p1_waddr = 24'd6; p1_wdata = 24'h111111;
        #1;
        n_cmp++; if (p1_wgnt !== 1'b1 || p0_wgnt !== 1'b0) begin
            n_bad++; $display("FAIL wr_p1_gnt got=%b%b want=10", p1_wgnt, p0_wgnt); end
        tick();
        p1_wreq = 0; p1_rreq = 1; p1_raddr = 24'd5;
        #1;
        n_cmp++; if (p1_rgnt !== 1'b1) begin n_bad++; $display("FAIL rd_p1_gnt got=%b want=1", p1_rgnt); end
        tick();
        p1_rreq = 0;
        n_cmp++; if (p1_rvalid !== 1'b1 || p0_rvalid !== 1'b0) begin
            n_bad++; $display("FAIL rd_p1_valid got=%b%b want=10", p1_rvalid, p0_rvalid); end
        n_cmp++; if (p1_rdata !== 24'h00ABCD) begin n_bad++; $display("FAIL rd_p1_data got=%h want=00abcd", p1_rdata); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rd_p1_err got=%b want=0", err); end
        tick();
        n_cmp++; if (p1_rvalid !== 1'b0 || p1_rdata !== 24'h00ABCD) begin
            n_bad++; $display("FAIL rd_p1_hold got=%b/%h want=0/00abcd", p1_rvalid, p1_rdata); end
    endtask

    task automatic test_contention();
        logic want_p1;
        p0_rreq = 1; p0_raddr = 24'd5; p1_rreq = 1; p1_raddr = 24'd6;
        for (int i = 0; i < 6; i++) begin
            want_p1 = (i % 2) == 1;
            #1;
            n_cmp++; if (p0_rgnt !== !want_p1 || p1_rgnt !== want_p1) begin
                n_bad++; $display("FAIL rd_rr_gnt[%0d] got=%b%b want=%b%b", i, p0_rgnt, p1_rgnt, !want_p1, want_p1); end
            tick();
            n_cmp++; if (p0_rvalid !== !want_p1 || p1_rvalid !== want_p1) begin
                n_bad++; $display("FAIL rd_rr_valid[%0d] got=%b%b want=%b%b", i, p0_rvalid, p1_rvalid, !want_p1, want_p1); end
            n_cmp++; if ((want_p1 ? p1_rdata : p0_rdata) !== (want_p1 ? 24'h111111 : 24'h00ABCD)) begin
                n_bad++; $display("FAIL rd_rr_data[%0d] got=%h/%h", i, p0_rdata, p1_rdata); end
        end
        idle();
        p0_wreq = 1; p0_waddr = 24'd30; p0_wdata = 24'h300000;
        p1_wreq = 1; p1_waddr = 24'd31; p1_wdata = 24'h310000;
        for (int i = 0; i < 6; i++) begin
            want_p1 = (i % 2) == 1;
            #1;
            n_cmp++; if (p0_wgnt !== !want_p1 || p1_wgnt !== want_p1) begin
                n_bad++; $display("FAIL wr_rr_gnt[%0d] got=%b%b want=%b%b", i, p0_wgnt, p1_wgnt, !want_p1, want_p1); end
            n_cmp++; if (m_waddr !== (want_p1 ? 24'd31 : 24'd30)) begin
                n_bad++; $display("FAIL wr_rr_addr[%0d] got=%0d want=%0d", i, m_waddr, want_p1 ? 31 : 30); end
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_bypass();
        p0_wreq = 1; p0_waddr = 24'd10; p0_wdata = 24'h777777;
        tick();
        p0_wdata = 24'h123456; p1_rreq = 1; p1_raddr = 24'd10;
        #1;
        n_cmp++; if (p0_wgnt !== 1'b1 || p1_rgnt !== 1'b1) begin
            n_bad++; $display("FAIL byp_gnt got=%b%b want=11", p0_wgnt, p1_rgnt); end
        tick();
        idle();
        n_cmp++; if (p1_rvalid !== 1'b1 || p1_rdata !== 24'h123456) begin
            n_bad++; $display("FAIL byp_data got=%b/%h want=1/123456", p1_rvalid, p1_rdata); end
        p1_rreq = 1;
        tick();
        p1_rreq = 0;
        n_cmp++; if (p1_rdata !== 24'h123456) begin n_bad++; $display("FAIL byp_mem got=%h want=123456", p1_rdata); end
        tick();
    endtask

    task automatic test_range();
        p1_wreq = 1; p1_waddr = 24'd2048; p1_wdata = 24'h0BADBA;
        #1;
        n_cmp++; if (p1_wgnt !== 1'b1 || m_wen !== 1'b0) begin
            n_bad++; $display("FAIL oor_wr got=%b%b want=10", p1_wgnt, m_wen); end
        tick();
        idle();
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL oor_wr_err got=%b want=1", err); end
        tick();
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL oor_wr_err_clr got=%b want=0", err); end
        p0_rreq = 1; p0_raddr = 24'hFFFFFF;
        #1;
        n_cmp++; if (p0_rgnt !== 1'b1) begin n_bad++; $display("FAIL oor_rd_gnt got=%b want=1", p0_rgnt); end
        tick();
        idle();
        n_cmp++; if ({p0_rvalid, err} !== 2'b11 || p0_rdata !== 24'h0) begin
            n_bad++; $display("FAIL oor_rd got=%b%b/%h want=11/000000", p0_rvalid, err, p0_rdata); end
        p0_rreq = 1; p1_wreq = 1; p1_waddr = 24'd3000;
        tick();
        idle();
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL oor_both_err got=%b want=1", err); end
        tick();
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL oor_both_single got=%b want=0", err); end
    endtask

    task automatic test_reset_mid_read();
        p0_rreq = 1; p0_raddr = 24'd5; p0_wreq = 1; p0_waddr = 24'd40; p0_wdata = 24'h000001;
        #1;
        n_cmp++; if (p0_rgnt !== 1'b1 || p0_wgnt !== 1'b1) begin
            n_bad++; $display("FAIL mid_gnt got=%b%b want=11", p0_rgnt, p0_wgnt); end
        tick();
        rst = 0;
        p1_rreq = 1; p1_raddr = 24'd6; p1_wreq = 1; p1_waddr = 24'd41; p1_wdata = 24'h000002;
        #1;
        n_cmp++; if (p0_rvalid !== 1'b0) begin n_bad++; $display("FAIL mid_squash got=%b want=0", p0_rvalid); end
        n_cmp++; if ({p0_rgnt, p1_rgnt, p0_wgnt, p1_wgnt, m_wen} !== 5'b00000) begin
            n_bad++; $display("FAIL mid_forced got=%b want=00000", {p0_rgnt, p1_rgnt, p0_wgnt, p1_wgnt, m_wen}); end
        tick();
        n_cmp++; if ({p0_rvalid, p1_rvalid} !== 2'b00) begin
            n_bad++; $display("FAIL mid_rvalid got=%b want=00", {p0_rvalid, p1_rvalid}); end
        rst = 1;
        #1;
        n_cmp++; if ({p0_rgnt, p1_rgnt, p0_wgnt, p1_wgnt} !== 4'b1010) begin
            n_bad++; $display("FAIL mid_ptr got=%b want=1010", {p0_rgnt, p1_rgnt, p0_wgnt, p1_wgnt}); end
        idle();
        tick();
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst = 0;
        p0_rreq = 0; p0_raddr = '0; p0_wreq = 0; p0_waddr = '0; p0_wdata = '0;
        p1_rreq = 0; p1_raddr = '0; p1_wreq = 0; p1_waddr = '0; p1_wdata = '0;
        test_reset();
        test_single_write();
        test_contention();
        test_bypass();
        test_range();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
